mac_result_requant: RTL and testbench

Downstream stage of the iterative MAC. It collects the 32-bit accumulator the MAC shifts out one byte per cycle, MSB first. It then applies optional ReLU, a programmable arithmetic right shift and int8 saturation, and buffers the 8-bit activations in a small FIFO. The FIFO is drained by a valid/ready consumer, such as the next layer's input loader or the pad driver.

---
 rtl/mac_result_requant.sv | 220 ++++++++++++++++++++++
 tb/tb_mac_result_requant.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_result_requant.sv
// mac_result_requant
//
// Downstream stage of the iterative MAC. It gathers the 32-bit accumulator
// that arrives one byte per cycle, MSB first, and requantises it to a signed
// int8 activation: arithmetic right shift, optional ReLU, then saturation.
// Results are buffered in a small circular FIFO that a valid/ready consumer
// drains.
//
// Build option:
//   REQUANT_ROUND_EN  defined   -> round half up: 1<<(shift-1) is added
//                                  before the shift (nothing when shift=0).
//                     undefined -> truncating (floor) arithmetic shift,
//                                  with no rounding adder.
//
// Parameters:
//   FIFO_DEPTH  output FIFO entries (power of two, >= 2)
//   SHIFT_W     width of the shift amount
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   in_byte    accumulator byte, first byte is acc[31:24]
//   in_valid   high for 4 consecutive cycles per word
//   shift      right-shift amount, sampled with the 4th byte
//   relu       clamp negative results to 0, sampled with the 4th byte
//   out_data   FIFO head, signed int8 (registered storage)
//   out_valid  FIFO not empty
//   out_ready  consumer accepts out_data on out_valid && out_ready
//   overflow   sticky: a finished word was dropped on a full FIFO
//   frame_err  sticky: in_valid dropped before a word was complete

module mac_result_requant #(
    parameter int FIFO_DEPTH = 4,
    parameter int SHIFT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               relu,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow,
    output logic               frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Collector states, kept as plain constants for compatibility with the
    // existing encoding.
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] B1   = 2'd1;
    localparam logic [1:0] B2   = 2'd2;
    localparam logic [1:0] B3   = 2'd3;

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    // ------------------------------------------------------------------
    // Byte collector
    // ------------------------------------------------------------------
    logic [1:0]         state;
    logic [31:0]        acc;
    logic [SHIFT_W-1:0] shift_q;
    logic               relu_q;
    logic               pend;

    // acc is a byte shift register: after four accepted bytes the first one
    // sits in acc[31:24]. A back-to-back word may shift its first byte in on
    // the same edge that writes the previous result, because the FIFO write
    // uses the pre-edge acc value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            pend      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // pend lives for exactly one cycle: the requant stage always
            // consumes it on the following edge.
            pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc   <= {acc[23:0], in_byte};
                        state <= B1;
                    end
                end
                B1: begin
                    if (in_valid) begin
                        acc   <= {acc[23:0], in_byte};
                        state <= B2;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                B2: begin
                    if (in_valid) begin
                        acc   <= {acc[23:0], in_byte};
                        state <= B3;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                B3: begin
                    if (in_valid) begin
                        acc     <= {acc[23:0], in_byte};
                        shift_q <= shift;
                        relu_q  <= relu;
                        pend    <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Requantisation (33-bit signed so the rounding add cannot wrap)
    // ------------------------------------------------------------------
    logic signed [32:0] wide;
    logic signed [32:0] sum;
    logic signed [32:0] shifted;
    logic signed [32:0] r;
    logic [7:0]         sat;

`ifdef REQUANT_ROUND_EN
    localparam logic [SHIFT_W-1:0] SH_ONE = SHIFT_W'(1);
    logic [SHIFT_W-1:0] shift_m1;
    logic signed [32:0] round_term;

    always_comb begin
        shift_m1   = shift_q - SH_ONE;
        round_term = '0;
        if (shift_q != '0) begin
            round_term = 33'sd1 <<< shift_m1;
        end
    end
`endif

    always_comb begin
        wide = $signed({acc[31], acc});
`ifdef REQUANT_ROUND_EN
        sum = wide + round_term;
`else
        sum = wide;
`endif
        shifted = sum >>> shift_q;

        r = shifted;
        if (relu_q && shifted[32]) begin
            r = '0;
        end

        if (r > 33'sd127) begin
            sat = 8'h7F;
        end else if (r < -33'sd128) begin
            sat = 8'h80;
        end else begin
            sat = r[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop   = out_ready && !empty;
        // When full, a simultaneous pop frees the head slot, which is the
        // same slot the write pointer addresses, so the push can proceed.
        push  = pend && (!full || pop);
    end

    // Storage is cleared on reset so out_data reads 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= sat;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (pend && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_data  = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;

endmodule

// File: tb/tb_mac_result_requant.sv
// Self-checking bench for mac_result_requant: a table of single-word
// requant vectors plus hand-written sequences for FIFO full, push+pop on
// full, frame errors and mid-word / mid-push reset.
// Inputs change on the falling edge and outputs are sampled there too.

module tb_mac_result_requant;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic [4:0] shift;
    logic       relu;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       frame_err;

    int checks;
    int errors;

    mac_result_requant #(
        .FIFO_DEPTH (4),
        .SHIFT_W    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .shift     (shift),
        .relu      (relu),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  sh;
        logic        rl;
        logic [7:0]  exp_trunc;
        logic [7:0]  exp_round;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives the bytes of one word on consecutive falling edges; returns
    // with the last byte presented but not yet accepted.
    task automatic send_bytes(input logic [31:0] w, input int n,
                              input logic [4:0] s, input logic r);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = w[31-8*i -: 8];
            shift    = s;
            relu     = r;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_v;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        shift     = 5'd0;
        relu      = 1'b0;
        out_ready = 1'b0;

        vecs[0]  = '{32'h00000500, 5'd4,  1'b0, 8'h50, 8'h50};
        vecs[1]  = '{32'h00000018, 5'd4,  1'b0, 8'h01, 8'h02};
        vecs[2]  = '{32'h00010000, 5'd0,  1'b0, 8'h7F, 8'h7F};
        vecs[3]  = '{32'hFFFFFF00, 5'd0,  1'b0, 8'h80, 8'h80};
        vecs[4]  = '{32'hFFFFFF00, 5'd0,  1'b1, 8'h00, 8'h00};
        vecs[5]  = '{32'hFFFFFFF9, 5'd1,  1'b0, 8'hFC, 8'hFD};
        vecs[6]  = '{32'h7FFFFFFF, 5'd31, 1'b0, 8'h00, 8'h01};
        vecs[7]  = '{32'h80000000, 5'd31, 1'b0, 8'hFF, 8'hFF};
        vecs[8]  = '{32'h0000007F, 5'd0,  1'b0, 8'h7F, 8'h7F};
        vecs[9]  = '{32'h00000080, 5'd0,  1'b0, 8'h7F, 8'h7F};
        vecs[10] = '{32'hFFFFFF80, 5'd0,  1'b0, 8'h80, 8'h80};
        vecs[11] = '{32'hFFFFFF7F, 5'd0,  1'b0, 8'h80, 8'h80};
        vecs[12] = '{32'h00000300, 5'd4,  1'b1, 8'h30, 8'h30};

        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_frame_err", frame_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic requant with out_ready held high: 2-cycle latency, one pop.
        out_ready = 1'b1;
        send_bytes(32'h00000500, 4, 5'd4, 1'b0);
        idle_cycle();
        chk("basic_lat_k", out_valid, 0);
        @(negedge clk);
        chk("basic_valid", out_valid, 1);
        chk("basic_data",  out_data,  8'h50);
        @(negedge clk);
        chk("basic_popped", out_valid, 0);
        out_ready = 1'b0;

        // Table of single-word vectors.
        for (int i = 0; i < 13; i++) begin
`ifdef REQUANT_ROUND_EN
            exp_v = vecs[i].exp_round;
`else
            exp_v = vecs[i].exp_trunc;
`endif
            send_bytes(vecs[i].word, 4, vecs[i].sh, vecs[i].rl);
            idle_cycle();
            chk($sformatf("vec%0d_lat", i), out_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, exp_v);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            chk($sformatf("vec%0d_empty", i), out_valid, 0);
        end
        chk("vec_no_overflow", overflow, 0);
        chk("vec_no_frame_err", frame_err, 0);

        // FIFO full: five back-to-back words, fifth one dropped.
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            send_bytes(32'(w), 4, 5'd0, 1'b0);
        end
        idle_cycle();
        repeat (2) @(negedge clk);
        chk("full_overflow", overflow, 1);
        chk("full_valid", out_valid, 1);
        out_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            chk($sformatf("full_pop%0d", w), out_data, 32'(w));
            chk($sformatf("full_valid%0d", w), out_valid, 1);
            @(negedge clk);
        end
        chk("full_drained", out_valid, 0);
        out_ready = 1'b0;

        // Push and pop on the same edge while full: both happen.
        do_reset();
        for (int w = 1; w <= 4; w++) begin
            send_bytes(32'(w), 4, 5'd0, 1'b0);
        end
        idle_cycle();
        repeat (2) @(negedge clk);
        chk("pp_full_no_ovf", overflow, 0);
        send_bytes(32'h00000009, 4, 5'd0, 1'b0);
        idle_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("pp_overflow", overflow, 0);
        out_ready = 1'b1;
        for (int w = 0; w < 4; w++) begin
            exp_v = (w == 3) ? 8'h09 : 8'(w + 2);
            chk($sformatf("pp_pop%0d", w), out_data, exp_v);
            @(negedge clk);
        end
        chk("pp_drained", out_valid, 0);
        out_ready = 1'b0;

        // Frame error: two bytes then in_valid drops; next word still fine.
        do_reset();
        send_bytes(32'h11223344, 2, 5'd0, 1'b0);
        idle_cycle();
        repeat (4) @(negedge clk);
        chk("ferr_flag", frame_err, 1);
        chk("ferr_no_push", out_valid, 0);
        send_bytes(32'h00000500, 4, 5'd4, 1'b0);
        idle_cycle();
        @(negedge clk);
        chk("ferr_next_valid", out_valid, 1);
        chk("ferr_next_data", out_data, 8'h50);
        chk("ferr_sticky", frame_err, 1);

        // Reset while in B2 with a stored entry and frame_err set.
        send_bytes(32'hAABBCCDD, 2, 5'd0, 1'b0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstb2_valid", out_valid, 0);
        chk("rstb2_data", out_data, 0);
        chk("rstb2_frame_err", frame_err, 0);
        chk("rstb2_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstb2_no_stale", out_valid, 0);
        chk("rstb2_no_ferr", frame_err, 0);
        send_bytes(32'h00010000, 4, 5'd0, 1'b0);
        idle_cycle();
        @(negedge clk);
        chk("rstb2_next_data", out_data, 8'h7F);
        chk("rstb2_next_valid", out_valid, 1);

        // Reset while a push is pending: the pending word must not land.
        do_reset();
        send_bytes(32'h00000500, 4, 5'd4, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstpend_no_push", out_valid, 0);
        chk("rstpend_data", out_data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
